capture_ctrl: RTL

Capture-control sequencer that sits directly downstream of `trigger_logic` in the scope datapath. It consumes `triggered` and sequences sample writes into the circular capture RAM. It produces the `armed` and `set_capture_done` signals that `trigger_logic` consumes. Each capture fills a pre-trigger window, waits for the trigger, records `trig_pos` post-trigger samples, then reports done and the trigger location.

---
 rtl/capture_pkg.sv | 18 +
 rtl/capture_wptr.sv | 25 ++
 rtl/capture_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/capture_pkg.sv
// capture_pkg: shared state encoding, default depth and trigger-position clamp for capture_ctrl
package capture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRETRIG,
        ARMED,
        POSTTRIG,
        DONE
    } cap_state_t;

    localparam int DEFAULT_ENTRIES = 512;

    function automatic int unsigned clamp_trig_pos(input int unsigned tp, input int unsigned entries);
        return (tp > entries - 1) ? entries - 1 : tp;
    endfunction

endpackage

// File: rtl/capture_wptr.sv
// capture_wptr: modulo-ENTRIES write pointer for the circular capture RAM
module capture_wptr
    import capture_pkg::*;
#(
    parameter int ENTRIES = DEFAULT_ENTRIES,
    parameter int AW      = $clog2(ENTRIES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc_i,
    output logic [AW-1:0] ptr_o
);

    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;

    assign ptr_d = (ptr_q == AW'(ENTRIES - 1)) ? '0 : ptr_q + AW'(1);
    assign ptr_o = ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else if (inc_i) ptr_q <= ptr_d;
    end

endmodule

// File: rtl/capture_ctrl.sv
// capture_ctrl: sequences pre-trigger fill, trigger wait and post-trigger capture into the circular RAM
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int ENTRIES = DEFAULT_ENTRIES,
    parameter int AW      = $clog2(ENTRIES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          capture_start,
    input  logic          capture_clr,
    input  logic          smpl_en,
    input  logic          triggered,
    input  logic [AW-1:0] trig_pos,
    output logic          armed,
    output logic          set_capture_done,
    output logic          capture_done,
    output logic          busy,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [AW-1:0] trig_addr
);

    // one extra bit so the pre-trigger count can reach ENTRIES when trig_pos is 0
    localparam int CW = $clog2(ENTRIES) + 1;

    cap_state_t    state_q;
    logic [CW-1:0] tp_q, tp_d;
    logic [CW-1:0] pre_cnt_q, pre_cnt_d;
    logic [CW-1:0] post_cnt_q, post_cnt_d;
    logic [CW-1:0] pre_thr;
    logic [AW-1:0] trig_addr_q;
    logic          armed_q, scd_q, done_q;
    logic          start_ok;

    assign busy      = state_q inside {PRETRIG, ARMED, POSTTRIG};
    assign we        = smpl_en & busy;
    assign start_ok  = capture_start & (state_q == IDLE || state_q == DONE);
    assign tp_d      = CW'(clamp_trig_pos(32'(trig_pos), ENTRIES));
    assign pre_cnt_d = (&pre_cnt_q) ? pre_cnt_q : pre_cnt_q + CW'(1);
    assign post_cnt_d = post_cnt_q + CW'(1);
    assign pre_thr   = CW'(ENTRIES) - tp_q;

    assign armed            = armed_q;
    assign set_capture_done = scd_q;
    assign capture_done     = done_q;
    assign trig_addr        = trig_addr_q;

    capture_wptr #(.ENTRIES(ENTRIES), .AW(AW)) u_wptr (
        .clk  (clk),
        .rst  (rst),
        .inc_i(we),
        .ptr_o(waddr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tp_q        <= '0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            trig_addr_q <= '0;
            armed_q     <= 1'b0;
            scd_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            scd_q <= 1'b0;
            if (start_ok) begin
                state_q    <= PRETRIG;
                tp_q       <= tp_d;
                pre_cnt_q  <= '0;
                post_cnt_q <= '0;
                done_q     <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        pre_cnt_q  <= '0;
                        post_cnt_q <= '0;
                        done_q     <= 1'b0;
                    end
                    PRETRIG: if (smpl_en) begin
                        pre_cnt_q <= pre_cnt_d;
                        if (pre_cnt_d == pre_thr) begin
                            state_q <= ARMED;
                            armed_q <= 1'b1;
                        end
                    end
                    // a sample coincident with the trigger still belongs to the pre-trigger window
                    ARMED: if (triggered) begin
                        trig_addr_q <= waddr;
                        armed_q     <= 1'b0;
                        if (tp_q == '0) begin
                            state_q <= DONE;
                            scd_q   <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= POSTTRIG;
                        end
                    end
                    POSTTRIG: if (smpl_en) begin
                        post_cnt_q <= post_cnt_d;
                        if (post_cnt_d == tp_q) begin
                            state_q <= DONE;
                            scd_q   <= 1'b1;
                            done_q  <= 1'b1;
                        end
                    end
                    DONE: if (capture_clr) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule
